// File: rtl/param_op_register_pkg.sv
// ============================================================================
//  Module      : param_op_register_pkg
//  Description : Shared command bit positions, the command vector type and
//                the command-count helper for param_op_register.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package param_op_register_pkg;

  localparam int NUM_CMDS = 6;

  // One-hot bit positions inside a command vector
  localparam int CMD_LOAD = 0;
  localparam int CMD_INC  = 1;
  localparam int CMD_DEC  = 2;
  localparam int CMD_CLR  = 3;
  localparam int CMD_SHL  = 4;
  localparam int CMD_SHR  = 5;

  typedef logic [NUM_CMDS-1:0] cmd_vec_t;

  // Number of asserted commands, kept at 3 bits so any multi-command cycle
  // is seen as a count above one rather than wrapping back to 0 or 1.
  function automatic logic [2:0] cmd_count(input cmd_vec_t c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < NUM_CMDS; i++) begin
      n = n + {2'b00, c[i]};
    end
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_op_register_if.sv
// ============================================================================
//  Module      : param_op_register_if
//  Description : Command/data bus between the control unit (master) and one
//                architectural register (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_op_register_if #(
  parameter int WIDTH = 16
);

  logic             load;
  logic             inc;
  logic             dec;
  logic             clr;
  logic             shl;
  logic             shr;
  logic             ser_in;
  logic             err_clr;
  logic [WIDTH-1:0] indata;
  logic [WIDTH-1:0] outdata;
  logic             carry;
  logic             zero;
  logic             err;

  modport master (
    output load, inc, dec, clr, shl, shr, ser_in, err_clr, indata,
    input  outdata, carry, zero, err
  );

  modport slave (
    input  load, inc, dec, clr, shl, shr, ser_in, err_clr, indata,
    output outdata, carry, zero, err
  );

endinterface

`default_nettype wire

// File: rtl/param_op_register_decode.sv
// ============================================================================
//  Module      : param_op_register_decode
//  Description : Combinational command decoder. Passes a single command
//                through as a one-hot select; flags any multi-command cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_op_register_decode
  import param_op_register_pkg::*;
(
  input  cmd_vec_t cmds,
  output cmd_vec_t sel,
  output logic     conflict
);

  logic [2:0] count;

  assign count = cmd_count(cmds);

  // Only a lone command is forwarded; zero or several commands select nothing
  always_comb begin
    sel      = '0;
    conflict = (count > 3'd1);
    if (count == 3'd1) begin
      sel = cmds;
    end
  end

endmodule

`default_nettype wire

// File: rtl/param_op_register.sv
// ============================================================================
//  Module      : param_op_register
//  Description : Parametrised datapath register with load/inc/dec/clr and
//                serial shift commands, carry/borrow capture, zero flag and a
//                sticky command-conflict error flag.
//                Optional macro PARAM_OP_REGISTER_SATURATE_EN: inc/dec
//                saturate at all-ones/zero instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_op_register
  import param_op_register_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst,
  param_op_register_if.slave bus
);

  cmd_vec_t         cmds;
  cmd_vec_t         sel;
  logic             conflict;
  logic [WIDTH-1:0] data_reg;
  logic [WIDTH-1:0] data_next;
  logic             carry_reg;
  logic             carry_next;
  logic             err_reg;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;

  // Pack the individual command lines into a vector at the package positions
  always_comb begin
    cmds           = '0;
    cmds[CMD_LOAD] = bus.load;
    cmds[CMD_INC]  = bus.inc;
    cmds[CMD_DEC]  = bus.dec;
    cmds[CMD_CLR]  = bus.clr;
    cmds[CMD_SHL]  = bus.shl;
    cmds[CMD_SHR]  = bus.shr;
  end

  param_op_register_decode u_decode (
    .cmds     (cmds),
    .sel      (sel),
    .conflict (conflict)
  );

  // Extended arithmetic: bit WIDTH is the carry out of inc / borrow of dec
  assign sum_ext  = {1'b0, data_reg} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_ext = {1'b0, data_reg} - {{WIDTH{1'b0}}, 1'b1};

  // Next-state mux; an empty select (idle or conflict) holds data and carry
  always_comb begin
    data_next  = data_reg;
    carry_next = carry_reg;
    if (sel[CMD_LOAD]) begin
      data_next  = bus.indata;
      carry_next = 1'b0;
    end else if (sel[CMD_INC]) begin
`ifdef PARAM_OP_REGISTER_SATURATE_EN
      data_next  = sum_ext[WIDTH] ? data_reg : sum_ext[WIDTH-1:0];
`else
      data_next  = sum_ext[WIDTH-1:0];
`endif
      carry_next = sum_ext[WIDTH];
    end else if (sel[CMD_DEC]) begin
`ifdef PARAM_OP_REGISTER_SATURATE_EN
      data_next  = diff_ext[WIDTH] ? data_reg : diff_ext[WIDTH-1:0];
`else
      data_next  = diff_ext[WIDTH-1:0];
`endif
      carry_next = diff_ext[WIDTH];
    end else if (sel[CMD_CLR]) begin
      data_next  = '0;
      carry_next = 1'b0;
    end else if (sel[CMD_SHL]) begin
      data_next  = {data_reg[WIDTH-2:0], bus.ser_in};
      carry_next = data_reg[WIDTH-1];
    end else if (sel[CMD_SHR]) begin
      data_next  = {bus.ser_in, data_reg[WIDTH-1:1]};
      carry_next = data_reg[0];
    end
  end

  // Register and carry update; reset overrides any command
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= RESET_VALUE;
      carry_reg <= 1'b0;
    end else begin
      data_reg  <= data_next;
      carry_reg <= carry_next;
    end
  end

  // Sticky conflict flag; a new conflict beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else if (conflict) begin
      err_reg <= 1'b1;
    end else if (bus.err_clr) begin
      err_reg <= 1'b0;
    end
  end

  assign bus.outdata = data_reg;
  assign bus.carry   = carry_reg;
  assign bus.err     = err_reg;
  assign bus.zero    = ~|data_reg;

endmodule

`default_nettype wire

// File: doc/param_op_register.md
Name: param_op_register

Overview:
- Parametrised successor to the 16-bit load/inc/clr datapath register of the basic computer (AC, DR, AR, PC, TR class).
- Generalised in width and reset value.
- Adds decrement, shift left/right with serial input, carry/borrow capture, a zero flag, and a sticky command-conflict error flag that replaces simulation-only diagnostics.
- Instantiated per architectural register; the control unit drives at most one command per cycle.

Parameters:
- WIDTH, 16, data width in bits (>=2).
- RESET_VALUE, 0, value loaded into outdata on rst; WIDTH bits wide.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- load  input  1  command: outdata <= indata.
- inc  input  1  command: outdata <= outdata + 1.
- dec  input  1  command: outdata <= outdata - 1.
- clr  input  1  command: outdata <= 0.
- shl  input  1  command: shift left; ser_in enters the LSB.
- shr  input  1  command: shift right; ser_in enters the MSB.
- ser_in  input  1  serial fill bit for shl/shr.
- err_clr  input  1  clears the sticky err flag.
- indata  input  WIDTH  parallel load data.
- outdata  output  WIDTH  register contents.
- carry  output  1  registered carry/borrow/shift-out bit.
- zero  output  1  combinational: 1 when outdata == 0.
- err  output  1  sticky: more than one command seen in a single cycle.

Behaviour:
- All state updates on the rising edge of clk. Results are visible one cycle after the command is sampled.
- rst has priority over everything: outdata <= RESET_VALUE, carry <= 0, err <= 0.
- Command count = load+inc+dec+clr+shl+shr, computed at 3-bit width, not 1-bit.
  - Count 0: outdata and carry hold.
  - Count 1: execute that command.
  - Count >1: outdata and carry hold; err <= 1.
- inc: arithmetic in WIDTH+1 bits; carry <= bit WIDTH of the sum. All-ones wraps to 0 with carry = 1.
- dec: 0 wraps to all-ones with carry = 1 (borrow); otherwise carry = 0.
- shl: outdata <= {outdata[WIDTH-2:0], ser_in}; carry <= old outdata[WIDTH-1].
- shr: outdata <= {ser_in, outdata[WIDTH-1:1]}; carry <= old outdata[0].
- load and clr both set carry <= 0.
- err behaviour:
  - Cleared by err_clr in a cycle with no conflict.
  - Conflict and err_clr in the same cycle: err = 1 (set wins).
  - err never affects the datapath.
- zero tracks outdata combinationally, including immediately after reset. zero = 1 after reset if RESET_VALUE == 0.
- No state machine beyond the register. Reset mid-sequence discards any pending carry or err.

Optional Feature:
- Macro: PARAM_OP_REGISTER_SATURATE_EN.
- When defined:
  - inc at all-ones holds all-ones and sets carry = 1.
  - dec at 0 holds 0 and sets carry = 1.
  - All other behaviour is unchanged.
- When undefined: modular wrap as specified above.

Decomposition:
- Shared package holds:
  - Command one-hot bit positions (CMD_LOAD..CMD_SHR) and NUM_CMDS = 6.
  - A function computing the command count.
- One natural sub-module: param_op_register_decode. It is combinational and takes the six command bits. It outputs a one-hot select and a conflict flag.
- The datapath mux and carry logic remain in the top module.

Test Plan:
- Reset: rst=1 for 1 cycle with RESET_VALUE=16'h1234 -> outdata=16'h1234, carry=0, err=0, zero=0.
- Load then inc wrap: load 16'hFFFF, then inc -> outdata=16'h0000, carry=1, zero=1. With SATURATE_EN -> outdata=16'hFFFF, carry=1.
- Dec borrow: clr, then dec -> outdata=16'hFFFF, carry=1. Then dec -> 16'hFFFE, carry=0.
- Shifts: load 16'h8001.
  - shl with ser_in=0 -> 16'h0002, carry=1.
  - shr with ser_in=1 -> 16'h8001, carry=0.
- Conflict: outdata=16'h00AA; assert load+inc with indata=16'h5555 -> outdata stays 16'h00AA, err=1.
  - err_clr plus another conflict in the same cycle -> err stays 1.
  - err_clr alone -> err=0.
- Synchronous reset priority: rst=1 together with load 16'hBEEF in the same cycle -> outdata=RESET_VALUE. Deasserting rst mid-burst of incs resumes counting from RESET_VALUE.
